ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the data bus and of the request and response data words.
REQ-002 Parameter ADDR_WIDTH, default 8: width of the memory address.
REQ-003 One clock; reset is asynchronous and active-low (clk, rst_n).
REQ-004 clk  in  1  rising-edge clock shared with the RAM.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller can accept a request; high only in IDLE.
REQ-008 req_we  in  1  1 = write, 0 = read; sampled at handshake.
REQ-009 req_addr  in  ADDR_WIDTH  request address; sampled at handshake.
REQ-010 req_wdata  in  DATA_WIDTH  write data; sampled at handshake.
REQ-011 rsp_valid  out  1  one-cycle pulse, read data valid.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data; holds its value until the next read completes.
REQ-013 address  out  ADDR_WIDTH  RAM address.
REQ-014 cs  out  1  RAM chip select, active-high.
REQ-015 oe  out  1  RAM output enable, active-high.
REQ-016 w_r1  out  1  RAM direction: 1 = write, 0 = read.
REQ-017 data  inout  DATA_WIDTH  shared tristate RAM data bus.

Function
REQ-018 A handshake occurs on a rising clk edge with req_valid=1 and req_ready=1; the request fields are captured into internal registers at that edge.
REQ-019 The FSM has five states: IDLE, WRITE, RD_ADDR, RD_DATA, TURN.
REQ-020 Transitions: IDLE to WRITE on a write handshake; IDLE to RD_ADDR on a read handshake; WRITE to IDLE; RD_ADDR to RD_DATA; RD_DATA to TURN; TURN to IDLE; IDLE with no handshake stays in IDLE.
REQ-021 address, cs, oe and w_r1 are registered outputs; address holds its last value when cs=0.
REQ-022 In WRITE: cs=1, w_r1=1, oe=0, address=captured address, and data is driven with the captured write data; the RAM stores the word at the end of WRITE.
REQ-023 The controller drives data only in WRITE; in every other state and during reset, data is released to all-Z.
REQ-024 In RD_ADDR and RD_DATA: cs=1, w_r1=0, oe=1, address=captured address.
REQ-025 At the end of RD_DATA, the controller samples data into rsp_rdata and asserts rsp_valid during TURN for exactly one cycle.
REQ-026 In TURN: cs=0, oe=0, w_r1=0; TURN is a bus-turnaround cycle, so a read is never followed by a drive of data on the next cycle.
REQ-027 In IDLE: cs=0, oe=0, w_r1=0.
REQ-028 Latency: for a handshake at edge k, a write occupies cycle k+1 and req_ready is high again in cycle k+2.
REQ-029 Latency: for a handshake at edge k, a read has rsp_valid=1 in cycle k+3 and req_ready is high again in cycle k+4.
REQ-030 While req_ready=0, req_valid is ignored; a held request is accepted on the first edge back in IDLE.
REQ-031 All ADDR_WIDTH address values are legal, including 0 and 2^ADDR_WIDTH-1; no wrap-around or address arithmetic is performed.
REQ-032 The controller never asserts w_r1=1 together with oe=1.

Reset
REQ-033 On rst_n=0, the following apply immediately, without a clock: state=IDLE; cs=0, oe=0, w_r1=0; address=0; data released to Z; rsp_valid=0; rsp_rdata=0.
REQ-034 A reset mid-transaction abandons the transaction: no rsp_valid is produced, and an interrupted write leaves the RAM content unspecified at that address.
REQ-035 After rst_n is released, req_ready=1 on the first clk cycle.

Verification
REQ-036 Bench connects the controller to the team's 8x256 RAM over a tristate data bus; in every scenario, X on data and multiple drivers on data are errors.
REQ-037 Write 0xA5 to address 0x10, then read 0x10 -> cs/w_r1 high in cycle k+1 only; rsp_valid in cycle k+3 of the read handshake with rsp_rdata=0xA5.
REQ-038 Write 0x00 to address 0x00 and 0xFF to address 0xFF, then read both -> rsp_rdata=0x00, then 0xFF; no aliasing between the two addresses.
REQ-039 Hold req_valid=1 continuously with a write/read/write/read sequence -> each request is accepted only in IDLE; TURN is observed as a cs=0 cycle before each following write; no bus contention.
REQ-040 Assert rst_n=0 in RD_DATA -> cs, oe and rsp_valid drop at once with no clock; no rsp_valid follows; req_ready=1 after release.
REQ-041 Hold req_valid=1 with changing req_addr while req_ready=0 -> only the address present at the handshake edge appears on address.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port asynchronous-SRAM controller with a valid/ready request port.
//
// Accepts one request at a time in IDLE. A write occupies one bus cycle and a read
// occupies two bus cycles. Every read is followed by a turnaround cycle so that the
// RAM has released the bus before the controller can drive it again.
//
// Ports
//   clk        in   rising-edge clock shared with the RAM
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  controller idle and able to accept a request
//   req_we     in   1 = write, 0 = read (sampled at handshake)
//   req_addr   in   request address (sampled at handshake)
//   req_wdata  in   write data (sampled at handshake)
//   rsp_valid  out  one-cycle pulse, rsp_rdata carries new read data
//   rsp_rdata  out  last read data, held until the next read completes
//   address    out  RAM address (registered, holds while cs=0)
//   cs         out  RAM chip select, active-high (registered)
//   oe         out  RAM output enable, active-high (registered)
//   w_r1       out  RAM direction, 1 = write, 0 = read (registered)
//   data       io   shared tristate RAM data bus
module ram_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  cs,
  output logic                  oe,
  output logic                  w_r1,
  inout  wire  [DATA_WIDTH-1:0] data
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdAddr,
    StRdData,
    StTurn
  } state_e;

  state_e                  state_q, state_d;
  logic                    handshake;

  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    cs_q, cs_d;
  logic                    oe_q, oe_d;
  logic                    w_r1_q, w_r1_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  assign handshake = req_valid && (state_q == StIdle);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = req_we ? StWrite : StRdAddr;
        end
      end
      StWrite:  state_d = StIdle;
      StRdAddr: state_d = StRdData;
      StRdData: state_d = StTurn;
      StTurn:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // RAM strobes are decoded from the next state so that the registered outputs line up
  // with the state they belong to in the following cycle.
  always_comb begin
    cs_d        = 1'b0;
    oe_d        = 1'b0;
    w_r1_d      = 1'b0;
    address_d   = address_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    if (handshake) begin
      // The request address is the captured address; it stays on the bus afterwards.
      address_d = req_addr;
      if (req_we) begin
        wdata_d = req_wdata;
      end
    end

    unique case (state_d)
      StWrite: begin
        cs_d   = 1'b1;
        w_r1_d = 1'b1;
      end
      StRdAddr, StRdData: begin
        cs_d = 1'b1;
        oe_d = 1'b1;
      end
      StTurn: begin
        rsp_valid_d = 1'b1;
      end
      default: begin
      end
    endcase

    // The RAM has been driving the bus for two cycles by the end of RD_DATA.
    if (state_q == StRdData) begin
      rsp_rdata_d = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      address_q   <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b0;
      oe_q        <= 1'b0;
      w_r1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      w_r1_q      <= w_r1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Bus is driven only while in WRITE; reset forces IDLE, which releases it at once.
  assign data = (state_q == StWrite) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign address   = address_q;
  assign cs        = cs_q;
  assign oe        = oe_q;
  assign w_r1      = w_r1_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Testbench for ram_ctrl: controller attached to an 8x256 asynchronous-read RAM over a
// tristate bus, directed scenarios plus random transactions against a reference memory.
module tb_ram_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] address;
  logic          cs;
  logic          oe;
  logic          w_r1;
  wire  [DW-1:0] data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory: contents the RAM must hold after all accepted writes.
  logic [DW-1:0] ref_mem [256];

  // RAM model: writes at the clock edge closing a write cycle, drives the bus on read.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (cs && w_r1) ram[address] <= data;
  end
  assign data = (cs && oe && !w_r1) ? ram[address] : {DW{1'bz}};

  ram_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .address  (address),
    .cs       (cs),
    .oe       (oe),
    .w_r1     (w_r1),
    .data     (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus rules checked every cycle outside reset: no write strobe with output enable,
  // and no undefined value whenever the bus should be driven.
  always @(negedge clk) begin
    if (rst_n) begin
      check("bus_excl", 32'(oe & w_r1), 32'd0);
      if (cs && (w_r1 || oe)) check("bus_known", 32'($isunknown(data)), 32'd0);
    end
  end

  // One transaction, called at a negedge. With hold=1 req_valid stays high afterwards
  // and the fields are scrambled while the controller is busy.
  task automatic do_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input bit hold, input bit expect_now);
    int waits = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (expect_now) check("held_accept_wait", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    @(negedge clk);
    check("busy_ready", 32'(req_ready), 32'd0);
    check("c1_cs", 32'(cs), 32'd1);
    check("c1_addr", 32'(address), 32'(a));
    if (we) begin
      check("wr_w_r1", 32'(w_r1), 32'd1);
      check("wr_oe", 32'(oe), 32'd0);
      check("wr_data", 32'(data), 32'(wd));
      ref_mem[a] = wd;
      @(negedge clk);
      check("wr_done_cs", 32'(cs), 32'd0);
      check("wr_done_w_r1", 32'(w_r1), 32'd0);
      check("wr_done_ready", 32'(req_ready), 32'd1);
    end else begin
      check("rd1_oe", 32'(oe), 32'd1);
      check("rd1_w_r1", 32'(w_r1), 32'd0);
      check("rd1_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("rd2_cs", 32'(cs), 32'd1);
      check("rd2_oe", 32'(oe), 32'd1);
      check("rd2_addr", 32'(address), 32'(a));
      check("rd2_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("turn_rsp_valid", 32'(rsp_valid), 32'd1);
      check("turn_rdata", 32'(rsp_rdata), 32'(ref_mem[a]));
      check("turn_cs", 32'(cs), 32'd0);
      check("turn_oe", 32'(oe), 32'd0);
      check("turn_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rd_done_ready", 32'(req_ready), 32'd1);
      check("rd_done_rsp", 32'(rsp_valid), 32'd0);
      check("rd_hold_rdata", 32'(rsp_rdata), 32'(ref_mem[a]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    #1;
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_w_r1", 32'(w_r1), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Basic write then read.
    do_txn(1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
    do_txn(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);

    // Address extremes, no aliasing.
    do_txn(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    do_txn(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    do_txn(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    do_txn(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Back-to-back with req_valid held high and fields changing while busy.
    do_txn(1'b1, 8'h22, 8'h5C, 1'b1, 1'b0);
    do_txn(1'b0, 8'h22, 8'h00, 1'b1, 1'b1);
    do_txn(1'b1, 8'h23, 8'h3E, 1'b1, 1'b1);
    do_txn(1'b0, 8'h23, 8'h00, 1'b1, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);

    // Random traffic with random idle gaps.
    for (int t = 0; t < 80; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(1'($urandom), AW'($urandom), DW'($urandom), 1'b0, 1'b0);
    end

    // Reset in the middle of RD_DATA.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_oe", 32'(oe), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_cs", 32'(cs), 32'd0);
    check("async_oe", 32'(oe), 32'd0);
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_addr", 32'(address), 32'd0);
    check("async_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
      check("ready_after_rst", 32'(req_ready), 32'd1);
    end
    do_txn(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
    do_txn(1'b0, 8'h23, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
